uart_cmd_assembler: RTL
=======================

// Module: uart_cmd_assembler
// PURPOSE
//  Sits directly downstream of UART_rcv. Consumes bytes via rx_rdy/rx_rdy_clr and assembles them
//  into a 16-bit command word, high byte first. Presents the word with a cmd_rdy/clr_cmd_rdy
//  handshake to the command processor. A partial frame is discarded when the inter-byte gap
//  exceeds a timeout.
// PARAMETERS
//  TIMEOUT_CYC  100000  max clk cycles from one byte to the next byte (~4 byte times @19200/50MHz)
//  CNT_W        $clog2(TIMEOUT_CYC+1)  localparam, timeout counter width
// PORTS
//  clk          in   1   system clock, all logic posedge
//  rst_n        in   1   asynchronous active-low reset
//  rx_data      in   8   byte from UART_rcv, valid while rx_rdy=1
//  rx_rdy       in   1   level from UART_rcv, held until cleared
//  rx_rdy_clr   out  1   one-cycle pulse: byte consumed
//  cmd          out  16  assembled command {hi,lo}
//  cmd_rdy      out  1   level: cmd valid, held until clr_cmd_rdy
//  clr_cmd_rdy  in   1   consumer acknowledge
//  timeout_err  out  1   one-cycle pulse: partial frame dropped on timeout
//  overrun      out  1   one-cycle pulse: new cmd completed while cmd_rdy still 1
//  chk_err      out  1   one-cycle pulse: checksum mismatch (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state=IDLE; cmd=0; cmd_rdy, rx_rdy_clr, timeout_err, overrun, chk_err=0; counter=0.
//  - Byte acceptance: rx_rdy is sampled only when rx_rdy_clr was 0 in the previous cycle.
//    This blanks the one cycle UART_rcv needs to drop rx_rdy. Accepted byte -> rx_rdy_clr=1 next cycle.
//  - FSM:
//    IDLE    --accept--> HI_GOT (capture hi, clear counter)
//    HI_GOT  --accept--> complete (no macro) or HI_LO_GOT (macro)
//    any non-IDLE state: counter increments each cycle; counter==TIMEOUT_CYC-1 with no accept
//      -> IDLE, timeout_err pulse, partial bytes discarded, cmd untouched.
//  - Completion: cmd<={hi,lo} and cmd_rdy<=1 in the cycle after the last byte is accepted
//    (latency 1); state -> IDLE.
//  - cmd_rdy clears the cycle after clr_cmd_rdy=1. Completion and clr_cmd_rdy in the same cycle:
//    set wins, cmd_rdy stays 1.
//  - Completion while cmd_rdy=1 and no clr that cycle: cmd overwritten, cmd_rdy stays 1,
//    overrun pulse.
//  - Accept and timeout in the same cycle: accept wins, counter cleared.
//  - clr_cmd_rdy while cmd_rdy=0: no effect. rx_rdy in IDLE never times out.
//  - Async reset mid-frame: immediate return to reset values; bytes in flight are lost.
// CONFIGURATION
//  UART_CMD_CHKSUM_EN defined:
//    - Frame is 3 bytes {hi,lo,chk}, state HI_LO_GOT added.
//    - Valid frame: (hi+lo+chk) mod 256 == 8'h00 -> completes as above.
//    - Invalid frame: chk_err pulse, no cmd/cmd_rdy change, -> IDLE.
//  Not defined: 2-byte frame, chk_err tied 0, no HI_LO_GOT state.
// STRUCTURE
//  - uart_cmd_pkg: typedef enum logic [1:0] {IDLE,HI_GOT,HI_LO_GOT} cmd_state_t;
//    localparam CMD_W=16; localparam logic [7:0] CHK_TARGET=8'h00.
//  - Sub-module uart_gap_timer: counter with clr/en inputs and expired output, parameter TIMEOUT_CYC.
//  - Rest is FSM plus byte registers in the top.
// TESTING
//  Bench chains UART_tx -> UART_rcv -> uart_cmd_assembler, TIMEOUT_CYC reduced to 3 byte times.
//  Check on every accept: rx_rdy_clr is exactly 1 cycle wide.
//  1. Send 0x35,0x18 -> cmd=16'h3518, cmd_rdy=1 held 50 cycles until clr_cmd_rdy, then 0 next cycle.
//  2. Send 0xF8, idle > TIMEOUT_CYC -> timeout_err single pulse, cmd stays 16'h3518;
//     then 0x97,0x01 -> cmd=16'h9701.
//  3. Send 0x12,0x34 then 0x56,0x78 with no clr -> overrun pulse once, cmd=16'h5678, cmd_rdy=1.
//  4. Assert clr_cmd_rdy exactly in the completion cycle of 0xAA,0x55 -> cmd_rdy=1, cmd=16'hAA55.
//  5. rst_n low after 0x35 accepted, release, send 0x18,0x35 -> cmd=16'h1835; all outputs 0 during reset.
//  6. UART_CMD_CHKSUM_EN: 0x35,0x18,0xB3 -> cmd=16'h3518;
//     0x35,0x18,0xB4 -> chk_err pulse, cmd_rdy stays 0.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command assembler.
// Optional feature macro: UART_CMD_CHKSUM_EN (3-byte frame with checksum byte).
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HI_GOT    = 2'd1,
        HI_LO_GOT = 2'd2
    } cmd_state_t;

    localparam int         CMD_W      = 16;
    localparam logic [7:0] CHK_TARGET = 8'h00;

    // Modulo-256 sum of the three frame bytes; a valid frame sums to CHK_TARGET.
    function automatic logic [7:0] chk_sum8(input logic [7:0] hi,
                                            input logic [7:0] lo,
                                            input logic [7:0] chk);
        return hi + lo + chk;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: cleared on demand, counts while enabled and
// flags expiry when it reaches TIMEOUT_CYC-1.
module uart_gap_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Gap counter: clear wins, otherwise count up and saturate at the expiry value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= ZERO_CNT;
        end else if (clr) begin
            cnt_r <= ZERO_CNT;
        end else if (en && (cnt_r != LAST_CNT)) begin
            cnt_r <= cnt_r + ONE_CNT;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles bytes from a UART receiver into a 16-bit command word (high byte
// first) and hands it to the command processor with a ready/clear handshake.
// A partial frame is dropped if the gap between bytes exceeds TIMEOUT_CYC.
// Optional feature macro: UART_CMD_CHKSUM_EN adds a third checksum byte;
// frames whose bytes do not sum to CHK_TARGET are dropped with chk_err.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_rdy,
    output logic             rx_rdy_clr,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    output logic             timeout_err,
    output logic             overrun,
    output logic             chk_err
);

    cmd_state_t       state_r;
    cmd_state_t       state_nxt_s;
    logic [7:0]       hi_r;
    logic [7:0]       hi_nxt_s;
    logic [CMD_W-1:0] cmd_r;
    logic [CMD_W-1:0] cmd_word_s;
    logic [CMD_W-1:0] cmd_nxt_s;
    logic             cmd_rdy_r;
    logic             cmd_rdy_nxt_s;
    logic             rx_rdy_clr_r;
    logic             timeout_err_r;
    logic             timeout_nxt_s;
    logic             overrun_r;
    logic             overrun_nxt_s;
    logic             complete_s;
    logic             accept_s;
    logic             tmr_clr_s;
    logic             tmr_en_s;
    logic             tmr_expired_s;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]       lo_r;
    logic [7:0]       lo_nxt_s;
    logic             chk_err_r;
    logic             chk_bad_s;
`endif

    // rx_rdy is ignored in the cycle rx_rdy_clr is high, giving the receiver
    // time to drop its level before it could be counted twice.
    assign accept_s = rx_rdy & ~rx_rdy_clr_r;

    // The gap timer only runs while a frame is partially received.
    assign tmr_en_s  = (state_r != IDLE);
    assign tmr_clr_s = accept_s | timeout_nxt_s | (state_r == IDLE);

    uart_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // Next-state logic: byte sequencing, completion and timeout decisions.
    always_comb begin
        state_nxt_s   = state_r;
        hi_nxt_s      = hi_r;
        cmd_word_s    = cmd_r;
        complete_s    = 1'b0;
        timeout_nxt_s = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
        lo_nxt_s      = lo_r;
        chk_bad_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    hi_nxt_s    = rx_data;
                    state_nxt_s = HI_GOT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HI_GOT: begin
                if (accept_s) begin
`ifdef UART_CMD_CHKSUM_EN
                    lo_nxt_s    = rx_data;
                    state_nxt_s = HI_LO_GOT;
`else
                    complete_s  = 1'b1;
                    cmd_word_s  = {hi_r, rx_data};
                    state_nxt_s = IDLE;
`endif
                end else if (tmr_expired_s) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = HI_GOT;
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            HI_LO_GOT: begin
                if (accept_s) begin
                    if (chk_sum8(hi_r, lo_r, rx_data) == CHK_TARGET) begin
                        complete_s = 1'b1;
                        cmd_word_s = {hi_r, lo_r};
                    end else begin
                        chk_bad_s = 1'b1;
                    end
                    state_nxt_s = IDLE;
                end else if (tmr_expired_s) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = HI_LO_GOT;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output-side next values: a completion beats a same-cycle clear, and
    // completing on top of an unread command flags an overrun.
    always_comb begin
        cmd_nxt_s     = cmd_r;
        cmd_rdy_nxt_s = cmd_rdy_r;
        overrun_nxt_s = 1'b0;
        if (complete_s) begin
            cmd_nxt_s     = cmd_word_s;
            cmd_rdy_nxt_s = 1'b1;
            overrun_nxt_s = cmd_rdy_r & ~clr_cmd_rdy;
        end else if (clr_cmd_rdy) begin
            cmd_rdy_nxt_s = 1'b0;
        end else begin
            cmd_rdy_nxt_s = cmd_rdy_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte holding registers and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r          <= 8'h00;
            cmd_r         <= {CMD_W{1'b0}};
            cmd_rdy_r     <= 1'b0;
            rx_rdy_clr_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            hi_r          <= hi_nxt_s;
            cmd_r         <= cmd_nxt_s;
            cmd_rdy_r     <= cmd_rdy_nxt_s;
            rx_rdy_clr_r  <= accept_s;
            timeout_err_r <= timeout_nxt_s;
            overrun_r     <= overrun_nxt_s;
        end
    end

`ifdef UART_CMD_CHKSUM_EN
    // Low byte holding register and checksum error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r      <= 8'h00;
            chk_err_r <= 1'b0;
        end else begin
            lo_r      <= lo_nxt_s;
            chk_err_r <= chk_bad_s;
        end
    end

    assign chk_err = chk_err_r;
`else
    assign chk_err = 1'b0;
`endif

    assign rx_rdy_clr  = rx_rdy_clr_r;
    assign cmd         = cmd_r;
    assign cmd_rdy     = cmd_rdy_r;
    assign timeout_err = timeout_err_r;
    assign overrun     = overrun_r;

endmodule
